// File: rtl/zhang_cnn_mul_arbiter_pkg.sv
// Shared types and widths for the zhang_cnn multiplier arbiter.
package zhang_cnn_mul_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int MUL_A_W = 16;
    localparam int MUL_B_W = 16;
    localparam int MUL_P_W = 32;

    // Index increment that wraps at n (requester ring).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/zhang_cnn_mul_arbiter_if.sv
// Requester/response bundle between the convolution datapath and the shared multiplier.
interface zhang_cnn_mul_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    import zhang_cnn_mul_arb_pkg::*;

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*MUL_A_W-1:0] req_a;
    logic [N_REQ*MUL_B_W-1:0] req_b;
    logic [N_REQ-1:0]         req_last;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [MUL_P_W-1:0]       rsp_p;
    logic                     rsp_last;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, req_last, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_last, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_last, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p, rsp_last, busy
    );

endinterface

// File: rtl/zhang_cnn_mul_arbiter_mul.sv
// Unsigned multiplier core; the single-stage variant is purely combinational.
module zhang_cnn_mul_mul_16ns_16ns_32_1 #(
    parameter int NUM_STAGE  = 1,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 32
) (
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    generate
        if (NUM_STAGE == 1) begin : g_comb
            assign dout = dout_WIDTH'(din0) * dout_WIDTH'(din1);
        end else begin : g_unsupported
            // Pipelined variants are not built in this datapath.
            assign dout = '0;
        end
    endgenerate

endmodule

// File: rtl/zhang_cnn_mul_arbiter.sv
// Round-robin arbiter with burst lock feeding a two-stage shared multiplier pipeline.
module zhang_cnn_mul_arbiter
    import zhang_cnn_mul_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    zhang_cnn_mul_arbiter_if.slave  bus
);

    arb_state_t           state_q;
    logic [ID_W-1:0]      owner_q;
    logic [ID_W-1:0]      rr_ptr_q;

    logic                 s1_valid_q;
    logic [MUL_A_W-1:0]   s1_a_q;
    logic [MUL_B_W-1:0]   s1_b_q;
    logic [ID_W-1:0]      s1_id_q;
    logic                 s1_last_q;

    logic                 s2_valid_q;
    logic [MUL_P_W-1:0]   s2_p_q;
    logic [ID_W-1:0]      s2_id_q;
    logic                 s2_last_q;

    logic                 s2_en;
    logic                 s1_en;
    logic                 accept;
    logic                 fire;
    logic [N_REQ-1:0]     eligible;
    logic [N_REQ-1:0]     ready_vec;
    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W-1:0]      grant_next_d;
    logic [ID_W-1:0]      owner_next_d;
    logic [MUL_A_W-1:0]   sel_a;
    logic [MUL_B_W-1:0]   sel_b;
    logic                 sel_last;
    logic [MUL_P_W-1:0]   mul_p;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] vld,
                                              input logic [ID_W-1:0]  ptr);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [ID_W:0]      res;
        int                 sum;
        dbl = {vld, vld};
        rot = dbl[ptr +: N_REQ];
        res = '0;
        sum = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = k + int'(ptr);
                if (sum >= N_REQ) sum = sum - N_REQ;
                res = {1'b1, ID_W'(sum)};
            end
        end
        return res;
    endfunction

    assign s2_en  = !s2_valid_q | bus.rsp_ready;
    assign s1_en  = !s1_valid_q | s2_en;
    assign accept = s1_en & ap_rst_n;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            // While locked only the owner may compete.
            assign eligible[gi]  = bus.req_valid[gi] &
                                   ((state_q == IDLE) | (owner_q == ID_W'(gi)));
            assign ready_vec[gi] = fire & (grant_idx == ID_W'(gi));
        end
    endgenerate

    assign {grant_found, grant_idx} = rr_pick(eligible, rr_ptr_q);
    assign fire          = accept & grant_found;
    assign bus.req_ready = ready_vec;

    assign sel_a        = bus.req_a[grant_idx*MUL_A_W +: MUL_A_W];
    assign sel_b        = bus.req_b[grant_idx*MUL_B_W +: MUL_B_W];
    assign sel_last     = bus.req_last[grant_idx];
    assign grant_next_d = ID_W'(wrap_inc(int'(grant_idx), N_REQ));
    assign owner_next_d = ID_W'(wrap_inc(int'(owner_q), N_REQ));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        if (sel_last) begin
                            rr_ptr_q <= grant_next_d;
                        end else begin
                            state_q <= LOCKED;
                            owner_q <= grant_idx;
                        end
                    end
                end
                LOCKED: begin
                    if (fire && sel_last) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= owner_next_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_p_q     <= '0;
            s2_id_q    <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= fire;
                if (fire) begin
                    s1_a_q    <= sel_a;
                    s1_b_q    <= sel_b;
                    s1_id_q   <= grant_idx;
                    s1_last_q <= sel_last;
                end
            end
            // S2 only moves when the consumer can take it, keeping rsp_* stable under stall.
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_p_q    <= mul_p;
                    s2_id_q   <= s1_id_q;
                    s2_last_q <= s1_last_q;
                end
            end
        end
    end

    zhang_cnn_mul_mul_16ns_16ns_32_1 #(
        .NUM_STAGE  (1),
        .din0_WIDTH (MUL_A_W),
        .din1_WIDTH (MUL_B_W),
        .dout_WIDTH (MUL_P_W)
    ) u_mul (
        .din0 (s1_a_q),
        .din1 (s1_b_q),
        .dout (mul_p)
    );

    assign bus.rsp_valid = s2_valid_q;
    assign bus.rsp_p     = s2_p_q;
    assign bus.rsp_id    = s2_id_q;
    assign bus.rsp_last  = s2_last_q;
    assign bus.busy      = s1_valid_q | s2_valid_q | (state_q == LOCKED);

endmodule

// File: doc/zhang_cnn_mul_arbiter.md
# zhang_cnn_mul_arbiter

Round-robin arbiter and two-stage pipeline controller that shares one 16×16 unsigned multiplier among `N_REQ` requesters in the zhang_cnn convolution datapath. Each requester presents operand pairs with a valid/ready handshake. It may lock the multiplier for a burst of beats, for example one kernel window's MAC sequence. Products return on a single shared response channel tagged with the requester ID.

## Interface
- `N_REQ`, 4: number of requesters; legal range 2..8.
- `ID_W`, 2: response ID width; must equal clog2(`N_REQ`).
- `ap_clk`  in  1  sole clock; all logic is rising-edge.
- `ap_rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  `N_REQ`  per-requester operand valid.
- `req_ready`  out  `N_REQ`  per-requester accept; at most one bit set.
- `req_a`  in  `N_REQ`*16  operand A; requester i occupies bits [16i+15:16i]; unsigned.
- `req_b`  in  `N_REQ`*16  operand B; same packing; unsigned.
- `req_last`  in  `N_REQ`  marks the final beat of a burst; 1 = single beat.
- `rsp_valid`  out  1  product valid.
- `rsp_ready`  in  1  consumer accept.
- `rsp_id`  out  `ID_W`  index of the requester that produced this product.
- `rsp_p`  out  32  exact unsigned product a*b.
- `rsp_last`  out  1  `req_last` of the originating beat.
- `busy`  out  1  high while either pipeline stage is valid or the state is LOCKED.

## Operation
- Pipeline stages:
  - S1 is the operand register: a, b, id, last and `s1_valid`.
  - The multiplier is combinational between S1 and S2.
  - S2 is the product register: it drives `rsp_p`, `rsp_id`, `rsp_last` and `rsp_valid` (= `s2_valid`).
- Advance enables:
  - `s2_en = !s2_valid | rsp_ready`.
  - `s1_en = !s1_valid | s2_en`.
  - `accept = s1_en`.
- Grant:
  - Combinational search of `req_valid`, starting at `rr_ptr` and wrapping modulo `N_REQ`.
  - `req_ready[g] = accept & (g is granted)`.
  - A beat is accepted when `req_valid[g] & req_ready[g]`.
  - `req_ready` may depend combinationally on `req_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- FSM with states IDLE and LOCKED, plus an `owner` register:
  - IDLE, beat accepted from i with last=1: stay IDLE; `rr_ptr` ← i+1 mod `N_REQ`.
  - IDLE, beat accepted from i with last=0: go to LOCKED; `owner` ← i.
  - LOCKED: only `owner` is eligible; other `req_valid` bits are ignored.
  - LOCKED, owner beat accepted with last=1: go to IDLE; `rr_ptr` ← owner+1 mod `N_REQ`.
  - LOCKED, owner has `req_valid` low: hold LOCKED. There is no timeout.
- Arithmetic: full 32-bit unsigned product with no truncation or saturation. 0xFFFF*0xFFFF = 0xFFFE0001.
- Ordering: responses emerge in acceptance order, and the pipeline never drops or duplicates a beat.
- While `rsp_valid`=1 and `rsp_ready`=0, all of `rsp_*` stay stable.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - `s1_valid`=`s2_valid`=0.
  - `rsp_valid`, `rsp_p`, `rsp_id`, `rsp_last` = 0.
  - `busy`=0, `rr_ptr`=0, state IDLE, `owner`=0.
  - `req_ready` is 0 while `ap_rst_n`=0.
- Latency: a beat accepted at edge k gives `rsp_valid`=1 after edge k+1, i.e. two register stages.
- Throughput: one beat per cycle while `rsp_ready`=1.
- Full stall: with `rsp_ready` held 0, the pipeline fills two beats, then `req_ready` goes all 0.
- Simultaneous events: when S2 drains and a new beat enters in the same cycle, both occur with no bubble.
- Reset mid-burst: in-flight beats and the lock are discarded, and the block returns to IDLE.

## Structure
- Shared package `zhang_cnn_mul_arb_pkg`:
  - `arb_state_t` enum {IDLE, LOCKED}.
  - Constants `MUL_A_W`=16, `MUL_B_W`=16, `MUL_P_W`=32.
- Sub-module: one instance of the existing `zhang_cnn_mul_mul_16ns_16ns_32_1`, with din0/din1/dout widths 16/16/32 and `NUM_STAGE`=1. It sits between S1 and S2.
- Grant logic is a local function (rotate, priority-encode, rotate back); it is not a separate module.

## Test plan
- **Single beat:** req0 a=3, b=5, last=1, `rsp_ready`=1 → two cycles later `rsp_p`=15, `rsp_id`=0, `rsp_last`=1; `rr_ptr`=1.
- **Round-robin fairness:** all four requesters valid continuously with single-beat traffic → grant order 0,1,2,3,0,…; one response per cycle.
- **Burst lock:** req1 sends 3 beats (last on the third) while req2 is valid → req2 is not granted until after req1's third beat; then req2 is granted and `rr_ptr`=2.
- **Backpressure:** `rsp_ready`=0 for 5 cycles under full load → exactly 2 beats are held; `rsp_*` stay stable; `req_ready`=0; after release, no loss and order is preserved.
- **Width corner:** a=b=0xFFFF → `rsp_p`=0xFFFE0001; a=0, b=0xFFFF → 0.
- **Reset mid-burst:** assert `ap_rst_n`=0 while LOCKED with 2 beats in flight → immediately `rsp_valid`=0 and `busy`=0; after release, req3 is granted first-come and `rr_ptr` starts from 0.
